// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: flash read port, instruction handshake,
// fetch enable and PC redirect.
interface fetch_unit_if #(
   parameter int ADDR_W = 24
);
   logic              en;
   logic              flash_re;
   logic [ADDR_W-1:0] flash_addr;
   logic [7:0]        flash_out;
   logic [31:0]       ir;
   logic [ADDR_W-1:0] ir_pc;
   logic              ir_valid;
   logic              ir_ready;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_target;
   logic              misalign;
   logic [ADDR_W-1:0] pc;

   modport master (
      input  en,
      input  flash_out,
      input  ir_ready,
      input  pc_load,
      input  pc_target,
      output flash_re,
      output flash_addr,
      output ir,
      output ir_pc,
      output ir_valid,
      output misalign,
      output pc
   );

   modport slave (
      output en,
      output flash_out,
      output ir_ready,
      output pc_load,
      output pc_target,
      input  flash_re,
      input  flash_addr,
      input  ir,
      input  ir_pc,
      input  ir_valid,
      input  misalign,
      input  pc
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads four flash bytes per instruction,
// assembles them little-endian and hands the word on via valid/ready.
module fetch_unit #(
   parameter int                ADDR_W       = 24,
   parameter int                READ_LATENCY = 2,
   parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
   input  logic       i_clk,
   input  logic       i_reset,
   fetch_unit_if.master bus
);

   localparam int CNT_W =
      (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic              r_flash_re;
   logic [ADDR_W-1:0] r_flash_addr;
   logic [31:0]       r_ir;
   logic [ADDR_W-1:0] r_ir_pc;
   logic              r_ir_valid;
   logic              r_misalign;
   logic [1:0]        r_byte_idx;
   logic [CNT_W-1:0]  r_cnt;

   logic [ADDR_W-1:0] w_target_al;
   logic [ADDR_W-1:0] w_pc_next;
   logic              w_capture;
   logic              w_last_byte;
   logic              w_accept;

   assign w_target_al = {bus.pc_target[ADDR_W-1:2], 2'b00};
   assign w_pc_next   = r_pc + ADDR_W'(4);
   assign w_capture   = (r_cnt == CNT_LAST);
   assign w_last_byte = (r_byte_idx == 2'd3);
   assign w_accept    = r_ir_valid & bus.ir_ready;

   // Fetch FSM: redirect first, then idle / byte read / hold handling
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_flash_re   <= 1'b0;
         r_flash_addr <= '0;
         r_ir         <= '0;
         r_ir_pc      <= '0;
         r_ir_valid   <= 1'b0;
         r_misalign   <= 1'b0;
         r_byte_idx   <= 2'd0;
         r_cnt        <= '0;
      end else begin
         r_misalign <= 1'b0;
         if (bus.pc_load) begin
            r_pc       <= w_target_al;
            r_misalign <= |bus.pc_target[1:0];
            r_ir_valid <= 1'b0;
            r_byte_idx <= 2'd0;
            r_cnt      <= '0;
            if (bus.en) begin
               r_state      <= S_READ;
               r_flash_re   <= 1'b1;
               r_flash_addr <= w_target_al;
            end else begin
               r_state    <= S_IDLE;
               r_flash_re <= 1'b0;
            end
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_flash_re <= 1'b0;
                  if (bus.en) begin
                     r_state      <= S_READ;
                     r_flash_re   <= 1'b1;
                     r_flash_addr <= r_pc;
                     r_byte_idx   <= 2'd0;
                     r_cnt        <= '0;
                  end
               end
               S_READ: begin
                  if (w_capture) begin
                     r_ir[{r_byte_idx, 3'b000} +: 8] <= bus.flash_out;
                     r_cnt <= '0;
                     if (w_last_byte) begin
                        r_ir_valid <= 1'b1;
                        r_ir_pc    <= r_pc;
                        r_flash_re <= 1'b0;
                        r_byte_idx <= 2'd0;
                        r_state    <= S_HOLD;
                     end else begin
                        r_byte_idx   <= r_byte_idx + 2'd1;
                        r_flash_addr <= r_flash_addr + ADDR_W'(1);
                     end
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_HOLD: begin
                  if (w_accept) begin
                     r_pc       <= w_pc_next;
                     r_ir_valid <= 1'b0;
                     r_byte_idx <= 2'd0;
                     r_cnt      <= '0;
                     if (bus.en) begin
                        r_state      <= S_READ;
                        r_flash_re   <= 1'b1;
                        r_flash_addr <= w_pc_next;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end
               end
               default: begin
                  r_state    <= S_IDLE;
                  r_flash_re <= 1'b0;
                  r_ir_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.flash_re   = r_flash_re;
   assign bus.flash_addr = r_flash_addr;
   assign bus.ir         = r_ir;
   assign bus.ir_pc      = r_ir_pc;
   assign bus.ir_valid   = r_ir_valid;
   assign bus.misalign   = r_misalign;
   assign bus.pc         = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed sequences, a vector table and
// a randomized run against an instruction-stream reference model.
module tb_fetch_unit;

   logic clk;
   logic rst_a;
   logic rst_b;
   int   n_err;
   int   n_chk;

   fetch_unit_if #(.ADDR_W(24)) bus_a ();
   fetch_unit_if #(.ADDR_W(24)) bus_b ();

   fetch_unit #(
      .ADDR_W(24), .READ_LATENCY(2), .RESET_PC(24'h000000)
   ) dut_a (
      .i_clk(clk), .i_reset(rst_a), .bus(bus_a)
   );

   fetch_unit #(
      .ADDR_W(24), .READ_LATENCY(2), .RESET_PC(24'hFFFFFC)
   ) dut_b (
      .i_clk(clk), .i_reset(rst_b), .bus(bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem [64];

   function automatic logic [7:0] fbyte(input logic [23:0] a);
      logic [23:0] t;
      if (a < 24'd64) return mem[a[5:0]];
      t = (a * 24'd37) ^ (a >> 5);
      return t[7:0];
   endfunction

   function automatic logic [31:0] word(input logic [23:0] a);
      return {fbyte(a + 24'd3), fbyte(a + 24'd2),
              fbyte(a + 24'd1), fbyte(a)};
   endfunction

   // flash model: data for the address appears two edges later
   logic [7:0] d1_a, d1_b;
   initial begin
      d1_a = 8'h00; d1_b = 8'h00;
      bus_a.flash_out = 8'h00; bus_b.flash_out = 8'h00;
   end
   always @(posedge clk) begin
      d1_a <= fbyte(bus_a.flash_addr);
      bus_a.flash_out <= d1_a;
      d1_b <= fbyte(bus_b.flash_addr);
      bus_b.flash_out <= d1_b;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic wait_valid(input string nm);
      int c;
      c = 0;
      while (!bus_a.ir_valid && c < 60) begin
         @(negedge clk);
         c++;
      end
      chk({nm, "_timeout"}, bus_a.ir_valid, 1'b1);
   endtask

   typedef struct {
      logic [23:0] target;
      logic [31:0] ir;
      logic [23:0] ir_pc;
      logic        mis;
   } vec_t;

   vec_t        vt [6];
   logic [31:0] prog [4];
   logic [23:0] trace [$];
   logic [23:0] m_pc;
   logic        m_mis;
   logic        p_hold;
   logic        acc;
   int          n_acc;
   int          cyc;
   int          k;
   int          bad;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_err = 0; n_chk = 0;
      prog[0] = 32'h02000283; prog[1] = 32'h02100303;
      prog[2] = 32'h006283b3; prog[3] = 32'h02700123;
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      for (int w = 0; w < 4; w++)
         for (int j = 0; j < 4; j++)
            mem[w*4+j] = prog[w][j*8 +: 8];

      vt[0] = '{24'h000000, 32'h02000283, 24'h000000, 1'b0};
      vt[1] = '{24'h000004, 32'h02100303, 24'h000004, 1'b0};
      vt[2] = '{24'h000008, 32'h006283b3, 24'h000008, 1'b0};
      vt[3] = '{24'h00000C, 32'h02700123, 24'h00000C, 1'b0};
      vt[4] = '{24'h00000D, 32'h02700123, 24'h00000C, 1'b1};
      vt[5] = '{24'h000006, 32'h02100303, 24'h000004, 1'b1};

      rst_a = 1'b1; rst_b = 1'b1;
      bus_a.en = 0; bus_a.ir_ready = 0; bus_a.pc_load = 0;
      bus_a.pc_target = '0;
      bus_b.en = 0; bus_b.ir_ready = 0; bus_b.pc_load = 0;
      bus_b.pc_target = '0;

      // reset state
      @(negedge clk);
      chk("rst_re", bus_a.flash_re, 1'b0);
      chk("rst_addr", bus_a.flash_addr, 24'h0);
      chk("rst_ir", bus_a.ir, 32'h0);
      chk("rst_irpc", bus_a.ir_pc, 24'h0);
      chk("rst_valid", bus_a.ir_valid, 1'b0);
      chk("rst_mis", bus_a.misalign, 1'b0);
      chk("rst_pc", bus_a.pc, 24'h0);
      chk("rst_pc_b", bus_b.pc, 24'hFFFFFC);
      rst_a = 1'b0; rst_b = 1'b0;
      bus_a.en = 1; bus_a.ir_ready = 1;

      // basic fetch and latency
      cyc = 0;
      while (!bus_a.flash_re && cyc < 20) begin
         @(negedge clk); cyc++;
      end
      chk("first_re", bus_a.flash_re, 1'b1);
      chk("first_addr", bus_a.flash_addr, 24'h0);
      cyc = 0;
      while (!bus_a.ir_valid && cyc < 40) begin
         @(negedge clk); cyc++;
      end
      chk("fetch_latency", cyc, 12);
      chk("basic_ir", bus_a.ir, 32'h02000283);
      chk("basic_irpc", bus_a.ir_pc, 24'h0);
      bus_a.en = 0;
      @(negedge clk);
      chk("basic_pc4", bus_a.pc, 24'h4);
      chk("basic_drop", bus_a.ir_valid, 1'b0);

      // sequential stream with address trace
      bus_a.pc_load = 1; bus_a.pc_target = 24'h0; bus_a.en = 1;
      @(negedge clk);
      bus_a.pc_load = 0;
      k = 0;
      for (int i = 0; i < 100 && k < 4; i++) begin
         if (bus_a.flash_re) trace.push_back(bus_a.flash_addr);
         if (bus_a.ir_valid) begin
            chk("stream_ir", bus_a.ir, prog[k]);
            chk("stream_irpc", bus_a.ir_pc, 24'(k*4));
            k++;
         end
         if (k < 4) @(negedge clk);
      end
      chk("stream_count", k, 4);
      bus_a.en = 0;
      @(negedge clk);
      chk("trace_len", trace.size(), 48);
      bad = 0;
      for (int i = 0; i < trace.size() && i < 48; i++)
         if (trace[i] !== 24'(i / 3)) bad++;
      chk("trace_addr", bad, 0);

      // backpressure
      bus_a.ir_ready = 0; bus_a.pc_load = 1;
      bus_a.pc_target = 24'h4; bus_a.en = 1;
      @(negedge clk);
      bus_a.pc_load = 0;
      wait_valid("bp");
      for (int i = 0; i < 20; i++) begin
         chk("bp_ir", bus_a.ir, 32'h02100303);
         chk("bp_irpc", bus_a.ir_pc, 24'h4);
         chk("bp_valid", bus_a.ir_valid, 1'b1);
         chk("bp_re", bus_a.flash_re, 1'b0);
         chk("bp_pc", bus_a.pc, 24'h4);
         @(negedge clk);
      end
      bus_a.ir_ready = 1;
      @(negedge clk);
      bus_a.ir_ready = 0;
      chk("bp_pc8", bus_a.pc, 24'h8);
      chk("bp_drop", bus_a.ir_valid, 1'b0);
      chk("bp_next_re", bus_a.flash_re, 1'b1);
      chk("bp_next_addr", bus_a.flash_addr, 24'h8);

      // redirect during byte 2
      bus_a.ir_ready = 1; bus_a.pc_load = 1; bus_a.pc_target = 24'h4;
      @(negedge clk);
      bus_a.pc_load = 0;
      cyc = 0;
      while (!(bus_a.flash_re && bus_a.flash_addr == 24'h6)
             && cyc < 20) begin
         @(negedge clk); cyc++;
      end
      chk("rd_byte2", bus_a.flash_addr, 24'h6);
      bus_a.pc_load = 1; bus_a.pc_target = 24'h20;
      @(negedge clk);
      bus_a.pc_load = 0;
      chk("rd_pc", bus_a.pc, 24'h20);
      chk("rd_valid", bus_a.ir_valid, 1'b0);
      wait_valid("rd");
      chk("rd_irpc", bus_a.ir_pc, 24'h20);
      chk("rd_ir", bus_a.ir, word(24'h20));
      bus_a.en = 0;
      @(negedge clk);

      // misaligned redirect
      bus_a.pc_load = 1; bus_a.pc_target = 24'h21;
      bus_a.en = 1; bus_a.ir_ready = 0;
      @(negedge clk);
      bus_a.pc_load = 0;
      chk("mis_pulse", bus_a.misalign, 1'b1);
      chk("mis_pc", bus_a.pc, 24'h20);
      @(negedge clk);
      chk("mis_clear", bus_a.misalign, 1'b0);
      wait_valid("mis");
      chk("mis_irpc", bus_a.ir_pc, 24'h20);
      chk("mis_ir", bus_a.ir, word(24'h20));
      bus_a.en = 0;

      // accept and redirect in the same cycle
      bus_a.ir_ready = 1; bus_a.pc_load = 1;
      bus_a.pc_target = 24'hC; bus_a.en = 1;
      @(negedge clk);
      bus_a.pc_load = 0;
      chk("sim_pc", bus_a.pc, 24'hC);
      chk("sim_valid", bus_a.ir_valid, 1'b0);
      wait_valid("sim");
      chk("sim_irpc", bus_a.ir_pc, 24'hC);
      chk("sim_ir", bus_a.ir, 32'h02700123);
      bus_a.en = 0;
      @(negedge clk);

      // vector table of redirect targets
      foreach (vt[i]) begin
         bus_a.pc_load = 1; bus_a.pc_target = vt[i].target;
         bus_a.en = 1; bus_a.ir_ready = 0;
         @(negedge clk);
         bus_a.pc_load = 0;
         chk("tbl_mis", bus_a.misalign, vt[i].mis);
         wait_valid("tbl");
         chk("tbl_ir", bus_a.ir, vt[i].ir);
         chk("tbl_irpc", bus_a.ir_pc, vt[i].ir_pc);
         bus_a.ir_ready = 1; bus_a.en = 0;
         @(negedge clk);
         bus_a.ir_ready = 0;
      end

      // randomized run against the instruction-stream model
      bus_a.pc_load = 1; bus_a.pc_target = 24'h0; bus_a.en = 0;
      @(negedge clk);
      bus_a.pc_load = 0;
      m_pc = 24'h0; m_mis = 1'b0; p_hold = 1'b0; n_acc = 0;
      for (int c = 0; c < 2000; c++) begin
         chk("rnd_pc", bus_a.pc, m_pc);
         chk("rnd_mis", bus_a.misalign, m_mis);
         if (p_hold) chk("rnd_hold", bus_a.ir_valid, 1'b1);
         if (bus_a.ir_valid) begin
            chk("rnd_ir", bus_a.ir, word(m_pc));
            chk("rnd_irpc", bus_a.ir_pc, m_pc);
         end
         bus_a.en = ($urandom_range(0, 7) != 0);
         bus_a.ir_ready = ($urandom_range(0, 2) != 0);
         bus_a.pc_load = ($urandom_range(0, 39) == 0);
         bus_a.pc_target = 24'($urandom_range(0, 255));
         acc = bus_a.ir_valid && bus_a.ir_ready;
         p_hold = bus_a.ir_valid && !bus_a.ir_ready && !bus_a.pc_load;
         m_mis = bus_a.pc_load && (bus_a.pc_target[1:0] != 2'b00);
         if (bus_a.pc_load) begin
            m_pc = bus_a.pc_target & ~24'h3;
         end else if (acc) begin
            m_pc = m_pc + 24'd4;
            n_acc++;
         end
         @(negedge clk);
      end
      bus_a.pc_load = 0; bus_a.en = 0;
      chk("rnd_progress", (n_acc > 20), 1'b1);

      // wrap at top of address space
      bus_b.en = 1; bus_b.ir_ready = 1;
      cyc = 0;
      while (!bus_b.ir_valid && cyc < 60) begin
         @(negedge clk); cyc++;
      end
      chk("wrap_valid", bus_b.ir_valid, 1'b1);
      chk("wrap_irpc", bus_b.ir_pc, 24'hFFFFFC);
      chk("wrap_ir", bus_b.ir, word(24'hFFFFFC));
      bus_b.en = 0;
      @(negedge clk);
      chk("wrap_pc0", bus_b.pc, 24'h0);

      // asynchronous reset during byte 1
      bus_b.en = 1; bus_b.ir_ready = 0;
      cyc = 0;
      while (!(bus_b.flash_re && bus_b.flash_addr == 24'h1)
             && cyc < 20) begin
         @(negedge clk); cyc++;
      end
      chk("ar_byte1", bus_b.flash_addr, 24'h1);
      #2 rst_b = 1'b1;
      #1;
      chk("ar_re", bus_b.flash_re, 1'b0);
      chk("ar_addr", bus_b.flash_addr, 24'h0);
      chk("ar_ir", bus_b.ir, 32'h0);
      chk("ar_irpc", bus_b.ir_pc, 24'h0);
      chk("ar_valid", bus_b.ir_valid, 1'b0);
      chk("ar_pc", bus_b.pc, 24'hFFFFFC);
      @(negedge clk);
      rst_b = 1'b0; bus_b.ir_ready = 1;
      @(negedge clk);
      chk("ar_restart_re", bus_b.flash_re, 1'b1);
      chk("ar_restart_addr", bus_b.flash_addr, 24'hFFFFFC);
      cyc = 0;
      while (!bus_b.ir_valid && cyc < 60) begin
         @(negedge clk); cyc++;
      end
      chk("ar_irpc2", bus_b.ir_pc, 24'hFFFFFC);
      chk("ar_ir2", bus_b.ir, word(24'hFFFFFC));
      bus_b.en = 0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits between the byte-wide flash and the control unit. It owns the program counter and issues four sequential byte reads. It assembles the bytes little-endian into a 32-bit instruction word. The word is presented downstream with a valid/ready handshake. Branch/jump redirects come from the execute side via a PC load port.

Parameters:
ADDR_W, 24, flash byte-address width and PC width.
READ_LATENCY, 2, cycles from the first clk edge with flash_re=1 and a stable flash_addr until flash_out holds that byte (range 1..7).
RESET_PC, 0, PC value after reset.

Ports:
clk  input  1  system clock, all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
en  input  1  fetch enable; when low, no new fetch starts.
flash_re  output  1  flash read enable, registered.
flash_addr  output  ADDR_W  flash byte address, registered.
flash_out  input  8  flash read data.
ir  output  32  assembled instruction; byte at PC in [7:0], PC+3 in [31:24].
ir_pc  output  ADDR_W  address of the instruction in ir.
ir_valid  output  1  ir/ir_pc valid.
ir_ready  input  1  downstream accepts ir this cycle.
pc_load  input  1  redirect request (single-cycle pulse).
pc_target  input  ADDR_W  redirect address.
misalign  output  1  one-cycle pulse: pc_target[1:0] was nonzero on pc_load.
pc  output  ADDR_W  current fetch PC.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: pc=RESET_PC, flash_re=0, flash_addr=0, ir=0, ir_pc=0, ir_valid=0, misalign=0. State=IDLE, byte_idx=0, wait counter=0.
- Reset mid-fetch: the fetch is abandoned immediately. No partial ir is ever presented.
- States: IDLE, READ, HOLD.
- IDLE: flash_re=0. If en=1, go to READ with byte_idx=0. flash_re=1 and flash_addr=pc are set on that edge.
- READ: flash_addr=pc+byte_idx, held stable for READ_LATENCY+1 cycles.
  - A counter runs 0..READ_LATENCY. On the edge where it equals READ_LATENCY, flash_out is written into ir lane byte_idx.
  - If byte_idx<3: byte_idx increments, flash_addr advances by 1, counter clears. flash_re stays 1.
  - If byte_idx==3: ir_valid<=1, ir_pc<=pc, flash_re<=0, go to HOLD.
- Fetch latency: 4*(READ_LATENCY+1) cycles from the first flash_re=1 cycle to ir_valid=1. This is 12 cycles at default.
- HOLD: ir, ir_pc and ir_valid stay stable while ir_ready=0.
  - On ir_valid&ir_ready: pc<=pc+4, wrapping modulo 2^ADDR_W, so 24'hFFFFFC goes to 0.
  - In that same cycle ir_valid<=0. If en=1, go to READ at the new pc (the next fetch starts the following cycle); otherwise go to IDLE.
- The unit does not prefetch. Only one instruction is in flight or held at any time.
- en deasserted mid-READ: the current instruction completes and is held. No new fetch starts after acceptance.
- Redirect (pc_load=1), valid in any state:
  - pc<=pc_target with bits [1:0] forced to 00. misalign<=|pc_target[1:0].
  - ir_valid<=0, byte_idx<=0, counter<=0. Any fetch in progress is discarded.
  - Next state is READ (flash_addr<=aligned target, flash_re=1) if en=1, else IDLE.
- pc_load has priority over a simultaneous ir_valid&ir_ready. In that case the held ir counts as consumed, and pc takes the target, not pc+4.
- flash_we is never driven by this block. Store traffic is arbitrated outside it.
- flash_out is sampled only on capture edges. X on flash_out at other times must not propagate.

Test Plan:
- Basic fetch: flash bytes 0x83,0x02,0x00,0x02 at 0x000000..3, en=1, ir_ready=1 -> ir=32'h02000283, ir_pc=0, ir_valid exactly 12 cycles after first flash_re; pc then 0x000004.
- Sequential stream: program 02000283, 02100303, 006283b3, 02700123 at 0x0/0x4/0x8/0xC, ir_ready=1 -> four words in order with ir_pc 0,4,8,C; flash_addr sequence 0..F with each address held 3 cycles.
- Backpressure: ir_ready=0 for 20 cycles after ir_valid -> ir/ir_pc constant, flash_re=0, pc unchanged; ir_ready=1 for one cycle -> pc+4 and the next fetch starts.
- Redirect mid-fetch: pc_load=1 with pc_target=0x000020 during byte 2 of the fetch at 0x4 -> no ir_valid for 0x4; next ir_pc=0x20. pc_target=0x000021 -> misalign pulse, fetch from 0x20.
- Simultaneous accept+redirect: ir_valid=1, ir_ready=1, pc_load=1 with target 0x0C in the same cycle -> pc=0x0C (not pc+4); next ir_pc=0x0C.
- Wrap and reset: RESET_PC=24'hFFFFFC, word accepted -> pc=0. Assert reset during byte 1 of a fetch -> all outputs at reset values asynchronously; after release, fetch restarts at RESET_PC.
